// File: rtl/fb_readback_pkg.sv
// Shared definitions for the frame-buffer readback checker: FSM states,
// CRC-16-CCITT constants and the "no mismatch seen" address marker.
package fb_readback_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [31:0] NO_ERR_ADDR = 32'hFFFF_FFFF;
  localparam logic [19:0] ERR_MAX     = 20'hFFFFF;

endpackage

// File: rtl/crc16_ccitt_step.sv
// One 16-bit step of CRC-16-CCITT (MSB first). Only exists when the
// FB_READBACK_CRC_EN build option is defined, so no CRC logic is built otherwise.
`ifdef FB_READBACK_CRC_EN
module crc16_ccitt_step
  import fb_readback_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [15:0] i_data,
  output logic [15:0] o_crc
);

  logic [15:0] w_crc;

  always_comb begin
    w_crc = i_crc;
    for (int i = 15; i >= 0; i--) begin
      if (w_crc[15] ^ i_data[i]) w_crc = {w_crc[14:0], 1'b0} ^ CRC_POLY;
      else                       w_crc = {w_crc[14:0], 1'b0};
    end
  end

  assign o_crc = w_crc;

endmodule
`endif

// File: rtl/fb_readback.sv
// Sweeps every pixel of the frame buffer, compares each read against an expected
// value and reports mismatches. Define FB_READBACK_CRC_EN to also CRC the read data.
module fb_readback
  import fb_readback_pkg::*;
#(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int TIMEOUT   = 4095
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        start_i,
  input  logic [15:0] expect_i,
  input  logic        vram_ack_i,
  input  logic [15:0] vram_data_in_i,
  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [3:0]  vram_mask_o,
  output logic [31:0] vram_addr_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [19:0] err_count_o,
  output logic [31:0] first_err_addr_o,
  output logic [15:0] crc_o
);

  localparam logic [19:0] LAST_ADDR = 20'(FB_WIDTH * FB_HEIGHT - 1);
  localparam int          WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [19:0]       r_addr;
  logic [WD_W-1:0]   r_wdog;
  logic [15:0]       r_expect;
  logic [15:0]       r_data;
  logic              r_sel;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;
  logic [19:0]       r_err;
  logic [31:0]       r_first;

`ifdef FB_READBACK_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_next;

  crc16_ccitt_step u_crc (
    .i_crc  (r_crc),
    .i_data (r_data),
    .o_crc  (w_crc_next)
  );

  assign crc_o = r_crc;
`else
  assign crc_o = 16'h0000;
`endif

  assign vram_sel_o       = r_sel;
  assign vram_wr_o        = 1'b0;
  assign vram_mask_o      = 4'hF;
  assign vram_addr_o      = {12'h000, r_addr};
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign timeout_o        = r_timeout;
  assign err_count_o      = r_err;
  assign first_err_addr_o = r_first;

  // The watchdog compare sits behind the ack test so a late ack always wins.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdog    <= '0;
      r_expect  <= '0;
      r_data    <= '0;
      r_sel     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= '0;
      r_first   <= NO_ERR_ADDR;
`ifdef FB_READBACK_CRC_EN
      r_crc     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_expect  <= expect_i;
            r_err     <= '0;
            r_timeout <= 1'b0;
            r_first   <= NO_ERR_ADDR;
            r_addr    <= '0;
            r_wdog    <= '0;
            r_sel     <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= REQ;
`ifdef FB_READBACK_CRC_EN
            r_crc     <= CRC_INIT;
`endif
          end
        end

        REQ: begin
          if (vram_ack_i) begin
            r_data  <= vram_data_in_i;
            r_sel   <= 1'b0;
            r_state <= CHECK;
          end else if (r_wdog == WD_LAST) begin
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= FINISH;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end

        CHECK: begin
          if (r_data != r_expect) begin
            if (r_err != ERR_MAX)       r_err   <= r_err + 20'd1;
            if (r_first == NO_ERR_ADDR) r_first <= {12'h000, r_addr};
          end
`ifdef FB_READBACK_CRC_EN
          r_crc <= w_crc_next;
`endif
          if (r_addr == LAST_ADDR) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_addr  <= r_addr + 20'd1;
            r_wdog  <= '0;
            r_sel   <= 1'b1;
            r_state <= REQ;
          end
        end

        FINISH: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_readback.sv
// Bench for fb_readback: a random-latency VRAM responder plus a plain array model
// of the sweep results. CRC expectations follow FB_READBACK_CRC_EN.
module tb_fb_readback;

  localparam int W    = 64;
  localparam int H    = 80;
  localparam int NPIX = W * H;
  localparam int TOUT = 15;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic        reset;
  logic        start;
  logic [15:0] expectVal;
  logic        vramAck;
  logic [15:0] vramData;
  logic        vramSel;
  logic        vramWr;
  logic [3:0]  vramMask;
  logic [31:0] vramAddr;
  logic        busy;
  logic        done;
  logic        timeoutFlag;
  logic [19:0] errCount;
  logic [31:0] firstErrAddr;
  logic [15:0] crc;

  logic        crcStart;
  logic [15:0] crcExpect;
  logic        crcAck;
  logic [15:0] crcData;
  logic        crcSel;
  logic        crcWr;
  logic [3:0]  crcMask;
  logic [31:0] crcAddr;
  logic        crcBusy;
  logic        crcDone;
  logic        crcTimeout;
  logic [19:0] crcErr;
  logic [31:0] crcFirst;
  logic [15:0] crcOut;

  fb_readback #(.FB_WIDTH(W), .FB_HEIGHT(H), .TIMEOUT(TOUT)) dut (
    .clk_pix(clk_pix), .reset(reset), .start_i(start), .expect_i(expectVal),
    .vram_ack_i(vramAck), .vram_data_in_i(vramData), .vram_sel_o(vramSel),
    .vram_wr_o(vramWr), .vram_mask_o(vramMask), .vram_addr_o(vramAddr),
    .busy_o(busy), .done_o(done), .timeout_o(timeoutFlag), .err_count_o(errCount),
    .first_err_addr_o(firstErrAddr), .crc_o(crc)
  );

  fb_readback #(.FB_WIDTH(4), .FB_HEIGHT(1), .TIMEOUT(TOUT)) dutCrc (
    .clk_pix(clk_pix), .reset(reset), .start_i(crcStart), .expect_i(crcExpect),
    .vram_ack_i(crcAck), .vram_data_in_i(crcData), .vram_sel_o(crcSel),
    .vram_wr_o(crcWr), .vram_mask_o(crcMask), .vram_addr_o(crcAddr),
    .busy_o(crcBusy), .done_o(crcDone), .timeout_o(crcTimeout), .err_count_o(crcErr),
    .first_err_addr_o(crcFirst), .crc_o(crcOut)
  );

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  logic [15:0] mem [NPIX];
  logic [15:0] crcMem [4];
  int noAckAddr = -1;
  int slowAddr  = -1;
  int fixedLat  = 1;
  int reqLog[$];
  int reqCycles = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

`ifdef FB_READBACK_CRC_EN
  logic [15:0] crcTable [256];

  function automatic logic [15:0] crcWord(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c;
    r = {r[7:0], 8'h00} ^ crcTable[r[15:8] ^ w[15:8]];
    r = {r[7:0], 8'h00} ^ crcTable[r[15:8] ^ w[7:0]];
    return r;
  endfunction
`endif

  // Expected results straight from the array: mismatch count, first bad address, CRC.
  task automatic modelSweep(input int n, input logic [15:0] e, output int errs,
                            output logic [31:0] first, output logic [15:0] expCrc);
    errs   = 0;
    first  = 32'hFFFF_FFFF;
    expCrc = 16'h0000;
`ifdef FB_READBACK_CRC_EN
    expCrc = 16'hFFFF;
`endif
    for (int a = 0; a < n; a++) begin
      if (mem[a] !== e) begin
        if (errs == 0) first = a;
        errs++;
      end
`ifdef FB_READBACK_CRC_EN
      expCrc = crcWord(expCrc, mem[a]);
`endif
    end
  endtask

  // VRAM responder: one ack per request after a chosen latency, stray acks while idle.
  initial begin
    bit pending, realAck, wasReal;
    int reqAddr, left;
    vramAck = 1'b0; vramData = 16'h0; pending = 0; realAck = 0; reqAddr = 0; left = 0;
    forever begin
      @(posedge clk_pix); #1;
      wasReal = realAck;
      if (vramAck) begin
        vramAck  = 1'b0;
        vramData = 16'($urandom);
        realAck  = 0;
        if (wasReal) checkOutput("selLowInCheck", vramSel, 0);
      end
      if (!wasReal) begin
        if (vramSel) begin
          if (!pending) begin
            pending = 1;
            reqCycles = 0;
            reqAddr = int'(vramAddr);
            reqLog.push_back(reqAddr);
            if (reqAddr == slowAddr) left = TOUT;
            else if (fixedLat > 0)   left = fixedLat;
            else                     left = int'($urandom_range(1, 10));
          end else begin
            checkOutput("addrStable", vramAddr, reqAddr);
          end
          reqCycles++;
          if (reqAddr != noAckAddr) begin
            left--;
            if (left == 0) begin
              vramAck  = 1'b1;
              vramData = mem[reqAddr];
              realAck  = 1;
              pending  = 0;
            end
          end
        end else begin
          pending = 0;
          if (!busy && $urandom_range(0, 7) == 0) begin
            vramAck  = 1'b1;
            vramData = 16'($urandom);
          end
        end
      end
    end
  end

  initial begin
    crcAck = 1'b0; crcData = 16'h0;
    forever begin
      @(posedge clk_pix); #1;
      if (crcAck) crcAck = 1'b0;
      else if (crcSel) begin
        crcAck  = 1'b1;
        crcData = crcMem[crcAddr[1:0]];
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] e);
    @(negedge clk_pix);
    start = 1'b1; expectVal = e;
    @(negedge clk_pix);
    start = 1'b0; expectVal = 16'($urandom);
  endtask

  task automatic waitDone(input int maxCycles, output bit seen);
    seen = 0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(posedge clk_pix); #1;
      if (done) seen = 1;
    end
  endtask

  task automatic runSweep(input string name, input logic [15:0] e, input int nChecked, input int nReq,
                          input bit expTimeout, input bit midStart, input int maxCycles);
    int startIdx, errs, bad;
    logic [31:0] first;
    logic [15:0] expCrc;
    bit seen;
    startIdx = reqLog.size();
    modelSweep(nChecked, e, errs, first, expCrc);
    applyStimulus(e);
    if (midStart) begin
      repeat (40) @(negedge clk_pix);
      start = 1'b1; expectVal = ~e;
      @(negedge clk_pix);
      start = 1'b0;
    end
    waitDone(maxCycles, seen);
    checkOutput({name, "/doneSeen"}, seen, 1);
    checkOutput({name, "/busyAtDone"}, busy, 0);
    checkOutput({name, "/timeout"}, timeoutFlag, expTimeout);
    checkOutput({name, "/errCount"}, errCount, errs);
    checkOutput({name, "/firstErr"}, firstErrAddr, first);
    checkOutput({name, "/crc"}, crc, expCrc);
    bad = 0;
    for (int k = 0; k < nReq && startIdx + k < reqLog.size(); k++)
      if (reqLog[startIdx + k] != k) bad++;
    checkOutput({name, "/reqOrder"}, bad, 0);
    checkOutput({name, "/reqCount"}, reqLog.size() - startIdx, nReq);
    @(posedge clk_pix); #1;
    checkOutput({name, "/donePulse"}, done, 0);
    repeat (4) @(posedge clk_pix); #1;
    checkOutput({name, "/holdErr"}, errCount, errs);
    checkOutput({name, "/holdFirst"}, firstErrAddr, first);
  endtask

  initial begin
    bit seen, sawDone;
    int crcErrs;
    logic [15:0] expCrc, e;

`ifdef FB_READBACK_CRC_EN
    for (int b = 0; b < 256; b++) begin
      logic [15:0] t;
      t = {8'(b), 8'h00};
      for (int j = 0; j < 8; j++) t = t[15] ? ({t[14:0], 1'b0} ^ 16'h1021) : {t[14:0], 1'b0};
      crcTable[b] = t;
    end
`endif

    reset = 1'b1; start = 1'b0; expectVal = 16'h0;
    crcStart = 1'b0; crcExpect = 16'h0;
    for (int a = 0; a < NPIX; a++) mem[a] = 16'h0F00;
    repeat (3) @(negedge clk_pix);
    checkOutput("rst/sel", vramSel, 0);
    checkOutput("rst/busy", busy, 0);
    checkOutput("rst/done", done, 0);
    checkOutput("rst/timeout", timeoutFlag, 0);
    checkOutput("rst/errCount", errCount, 0);
    checkOutput("rst/firstErr", firstErrAddr, 32'hFFFF_FFFF);
    checkOutput("rst/crc", crc, 0);
    checkOutput("rst/wr", vramWr, 0);
    checkOutput("rst/mask", vramMask, 4'hF);
    checkOutput("rst/crcInst", crcOut, 0);
    @(negedge clk_pix);
    reset = 1'b0;

    $display("[TB] clean sweep, latency 1");
    fixedLat = 1;
    runSweep("clean", 16'h0F00, NPIX, NPIX, 0, 0, 20000);

    $display("[TB] corrupted sweep, random latency, late ack at 2000, start while busy");
    mem[1000] = 16'h0F01; mem[5000] = 16'h8F00;
    fixedLat = 0; slowAddr = 2000;
    runSweep("corrupt", 16'h0F00, NPIX, NPIX, 0, 1, 70000);

    $display("[TB] timeout sweep, no ack at address 7");
    slowAddr = -1; fixedLat = 0; mem[3] = 16'hBEEF; noAckAddr = 7;
    runSweep("timeout", 16'h0F00, 7, 8, 1, 0, 500);
    checkOutput("timeout/selHighCycles", reqCycles, TOUT);
    noAckAddr = -1; mem[3] = 16'h0F00;

    $display("[TB] reset mid-sweep, then fresh sweep");
    fixedLat = 1; mem[50] = 16'h0000;
    applyStimulus(16'h0F00);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk_pix); #1;
      if (vramSel && vramAddr == 32'd100) seen = 1;
    end
    checkOutput("abort/reachAddr100", seen, 1);
    @(negedge clk_pix);
    reset = 1'b1;
    sawDone = 0;
    repeat (3) begin @(posedge clk_pix); #1; if (done) sawDone = 1; end
    @(negedge clk_pix);
    reset = 1'b0;
    repeat (3) begin @(posedge clk_pix); #1; if (done) sawDone = 1; end
    checkOutput("abort/noDone", sawDone, 0);
    checkOutput("abort/errCleared", errCount, 0);
    checkOutput("abort/firstCleared", firstErrAddr, 32'hFFFF_FFFF);
    checkOutput("abort/busy", busy, 0);
    checkOutput("abort/sel", vramSel, 0);
    runSweep("afterAbort", 16'h0F00, NPIX, NPIX, 0, 0, 20000);

    $display("[TB] CRC instance, zero data then random data");
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 4; a++) crcMem[a] = (pass == 0) ? 16'h0000 : 16'($urandom);
      e = (pass == 0) ? 16'h0000 : crcMem[2];
      crcErrs = 0;
      expCrc = 16'h0000;
`ifdef FB_READBACK_CRC_EN
      expCrc = 16'hFFFF;
      for (int a = 0; a < 4; a++) expCrc = crcWord(expCrc, crcMem[a]);
`endif
      for (int a = 0; a < 4; a++) if (crcMem[a] !== e) crcErrs++;
      @(negedge clk_pix);
      crcStart = 1'b1; crcExpect = e;
      @(negedge clk_pix);
      crcStart = 1'b0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(posedge clk_pix); #1;
        if (crcDone) seen = 1;
      end
      checkOutput("crc/doneSeen", seen, 1);
      checkOutput("crc/value", crcOut, expCrc);
      checkOutput("crc/errCount", crcErr, crcErrs);
      repeat (3) @(posedge clk_pix);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fb_readback.md
FB_READBACK -- requirements
Module: fb_readback

Interface
REQ-001 The block SHALL expose parameter FB_WIDTH, default 640, meaning pixels per line.
REQ-002 The block SHALL expose parameter FB_HEIGHT, default 480, meaning lines per frame.
REQ-003 The block SHALL expose parameter TIMEOUT, default 4095, meaning maximum clk_pix cycles to wait for vram_ack_i per read.
REQ-004 Ports SHALL be the following (name, direction, width, meaning):
  clk_pix  in  1  pixel clock; all logic on rising edge.
  reset  in  1  synchronous, active-high reset.
  start_i  in  1  one-cycle pulse that begins a sweep.
  expect_i  in  16  expected pixel value; sampled on start_i.
  vram_ack_i  in  1  one-cycle read completion.
  vram_data_in_i  in  16  read data; valid only with vram_ack_i.
  vram_sel_o  out  1  read request.
  vram_wr_o  out  1  always 0.
  vram_mask_o  out  4  always 4'hF.
  vram_addr_o  out  32  pixel address.
  busy_o  out  1  sweep in progress.
  done_o  out  1  one-cycle pulse at sweep end.
  timeout_o  out  1  sticky; last sweep aborted on timeout.
  err_count_o  out  20  mismatch count, saturating.
  first_err_addr_o  out  32  address of first mismatch; 32'hFFFF_FFFF if none.
  crc_o  out  16  CRC of read data (only when the CRC feature is compiled in; see Configuration).

Function
REQ-005 The FSM SHALL have states IDLE, REQ, CHECK and FINISH.
REQ-006 IDLE SHALL wait for start_i; on start_i: latch expect_i, clear err_count_o, timeout_o and the CRC, set first_err_addr_o to all-ones, set the address to 0, and go to REQ.
REQ-007 In REQ, vram_sel_o SHALL be 1 and vram_addr_o SHALL be stable until vram_ack_i is seen.
REQ-008 vram_sel_o SHALL fall in the cycle after vram_ack_i is sampled, and the FSM SHALL go to CHECK.
REQ-009 CHECK SHALL last one cycle, using data captured at the ack cycle: on mismatch, err_count_o increments, saturating at 20'hFFFFF.
REQ-010 On the first mismatch of a sweep, CHECK SHALL load the current address into first_err_addr_o.
REQ-011 Address SHALL be y*FB_WIDTH+x and increment by 1 per pixel; after address FB_WIDTH*FB_HEIGHT-1, the FSM SHALL go to FINISH, otherwise to REQ.
REQ-012 The address register SHALL be 20-bit, zero-extended to 32 bits.
REQ-013 A watchdog counter SHALL clear on entry to REQ and increment each REQ cycle without an ack.
REQ-014 When the watchdog reaches TIMEOUT, the block SHALL drop vram_sel_o, set timeout_o and go to FINISH.
REQ-015 FINISH SHALL pulse done_o for exactly one cycle and return to IDLE; busy_o SHALL be 1 in REQ and CHECK, 0 otherwise.
REQ-016 start_i while busy_o is 1 SHALL be ignored.
REQ-017 vram_ack_i while not in REQ SHALL be ignored.
REQ-018 If ack and watchdog expiry occur in the same cycle, the ack SHALL win.
REQ-019 Results SHALL hold their values from done_o until the next accepted start_i.

Reset
REQ-020 Reset SHALL force IDLE and set vram_sel_o=0, busy_o=0, done_o=0, timeout_o=0, err_count_o=0, first_err_addr_o=32'hFFFF_FFFF, crc_o=0.
REQ-021 Reset mid-sweep SHALL abort with no done_o pulse.

Configuration
REQ-022 With FB_READBACK_CRC_EN defined, CHECK SHALL update crc_o over each read word (CRC-16-CCITT, polynomial 16'h1021, init 16'hFFFF, MSB first, 16 bits per cycle).
REQ-023 With FB_READBACK_CRC_EN undefined, crc_o SHALL be tied to 16'h0000 and no CRC logic SHALL be synthesized.

Structure
REQ-024 A shared package fb_readback_pkg SHALL hold the FSM state enum, the CRC polynomial and init constants, and the all-ones no-error address constant.
REQ-025 The CRC next-state function SHALL be one sub-module, crc16_ccitt_step (combinational, 16-bit data in), instantiated only under FB_READBACK_CRC_EN.

Verification
REQ-026 The bench SHALL cover these scenarios:
  Fill model with 16'h0F00, start_i with expect_i=16'h0F00 -> done_o after 307200 reads, err_count_o=0, first_err_addr_o=32'hFFFF_FFFF, timeout_o=0.
  Corrupt model addresses 1000 and 5000 -> err_count_o=2, first_err_addr_o=1000.
  Model never acks at address 7, TIMEOUT=15 -> vram_sel_o falls after 15 REQ cycles, timeout_o=1, done_o pulses, err_count_o reflects addresses 0-6 only.
  Ack latency varied 1-10 cycles randomly -> every address requested exactly once in order; vram_sel_o never high in CHECK.
  Reset asserted at address 100, then a fresh start_i -> no done_o during abort; second sweep runs from address 0 with cleared results.
  FB_READBACK_CRC_EN defined, FB_WIDTH=4, FB_HEIGHT=1, data 16'h0000 x4 -> crc_o matches the reference CCITT model; macro undefined -> crc_o=0.
